// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared fetch constants: reset vector, region tags, next-PC select codes
// Also provides the fetch legality check used by the PC register stage.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;
  localparam logic [3:0]  BIOS_REGION      = 4'h4;
  localparam logic [3:0]  IMEM_REGION      = 4'h1;
  localparam int          PC_SEL_W         = 3;

  typedef enum logic [PC_SEL_W-1:0] {
    PC_SEL_RESET  = 3'd0,
    PC_SEL_FLUSH  = 3'd1,
    PC_SEL_HOLD   = 3'd2,
    PC_SEL_TARGET = 3'd3,
    PC_SEL_SEQ    = 3'd4
  } pc_sel_e;

  // Offset bits above a region's word-address width must be zero.
  function automatic logic pc_legal(input logic [31:0] pc, input int bios_aw, input int imem_aw);
    logic [27:0] off;
    off = pc[27:0];
    if (pc[1:0] != 2'b00) return 1'b0;
    if (pc[31:28] == BIOS_REGION) return (off >> (bios_aw + 2)) == 28'd0;
    if (pc[31:28] == IMEM_REGION) return (off >> (imem_aw + 2)) == 28'd0;
    return 1'b0;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - redirect/stall control bundle from decode and execute into fetch
interface if_stage_if;
  logic        ex_flush;
  logic [31:0] ex_target;
  logic [31:0] id_target;
  logic        id_target_taken;
  logic        id_stall;
  logic        ex_stall;

  modport master (
    output ex_flush, ex_target, id_target, id_target_taken, id_stall, ex_stall
  );

  modport slave (
    input ex_flush, ex_target, id_target, id_target_taken, id_stall, ex_stall
  );
endinterface

// File: rtl/if_stage_perf_cnt.sv
// rtl/if_stage_perf_cnt.sv - fetch, redirect and stall event counters (wrap at 2^32)
module if_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic        stall,
  input  logic        ex_flush,
  output logic [31:0] fetch_cnt,
  output logic [31:0] redirect_cnt,
  output logic [31:0] stall_cnt
);
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (id_valid && !stall && !ex_flush) fetch_cnt <= fetch_cnt + 32'd1;
      if (ex_flush) redirect_cnt <= redirect_cnt + 32'd1;
      if (stall && !ex_flush) stall_cnt <= stall_cnt + 32'd1;
    end
  end
endmodule

// File: rtl/mux.sv
// rtl/mux.sv - generic 2**SW-way one-hot-free select mux
module mux #(
  parameter int W  = 32,
  parameter int SW = 3
) (
  input  logic [(2**SW)-1:0][W-1:0] din,
  input  logic [SW-1:0]             sel,
  output logic [W-1:0]              dout
);
  assign dout = din[sel];
endmodule

// File: rtl/pipeline_reg.sv
// rtl/pipeline_reg.sv - pipeline register with synchronous active-high reset to RESET_VAL
module pipeline_reg #(
  parameter int         W         = 32,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst) q <= RESET_VAL;
    else     q <= d;
  end
endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: next-PC select, memory addressing, sticky fetch fault
// Optional counters built only when IF_PERF_CNT_EN is defined.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          BIOS_AW  = 12,
  parameter int          IMEM_AW  = 14
) (
  input  logic               clk,
  input  logic               rst,
  if_stage_if.slave          ctrl,
  output logic [31:0]        if_pc,
  output logic [BIOS_AW-1:0] if_bios_addr,
  output logic [IMEM_AW-1:0] if_imem_addr,
  output logic [31:0]        id_pc,
  output logic               id_valid,
  output logic               if_fault,
  output logic [31:0]        if_fault_pc,
  output logic [31:0]        if_fetch_cnt,
  output logic [31:0]        if_redirect_cnt,
  output logic [31:0]        if_stall_cnt
);

  logic                           stall;
  logic                           fetch_legal;
  pc_sel_e                        pc_sel;
  logic [(2**PC_SEL_W)-1:0][31:0] pc_cand;

  assign stall = ctrl.id_stall | ctrl.ex_stall;

  // Flush outranks stall so a redirect is never lost; stall outranks a taken
  // target so the held branch re-resolves after release.
  always_comb begin
    pc_sel = PC_SEL_SEQ;
    if (rst)                       pc_sel = PC_SEL_RESET;
    else if (ctrl.ex_flush)        pc_sel = PC_SEL_FLUSH;
    else if (stall)                pc_sel = PC_SEL_HOLD;
    else if (ctrl.id_target_taken) pc_sel = PC_SEL_TARGET;
  end

  always_comb begin
    pc_cand                = '0;
    pc_cand[PC_SEL_RESET]  = RESET_PC;
    pc_cand[PC_SEL_FLUSH]  = ctrl.ex_target;
    pc_cand[PC_SEL_HOLD]   = id_pc;
    pc_cand[PC_SEL_TARGET] = ctrl.id_target;
    pc_cand[PC_SEL_SEQ]    = id_pc + 32'd4;
  end

  mux #(.W(32), .SW(PC_SEL_W)) u_pc_mux (
    .din  (pc_cand),
    .sel  (pc_sel),
    .dout (if_pc)
  );

  pipeline_reg #(.W(32), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .d   (if_pc),
    .q   (id_pc)
  );

  assign if_bios_addr = if_pc[BIOS_AW+1:2];
  assign if_imem_addr = if_pc[IMEM_AW+1:2];
  assign fetch_legal  = pc_legal(if_pc, BIOS_AW, IMEM_AW);

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid    <= 1'b1;
      if_fault    <= 1'b0;
      if_fault_pc <= '0;
    end else begin
      id_valid <= fetch_legal;
      if (!fetch_legal && !if_fault) begin
        if_fault    <= 1'b1;
        if_fault_pc <= if_pc;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  if_perf_cnt u_perf_cnt (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .stall        (stall),
    .ex_flush     (ctrl.ex_flush),
    .fetch_cnt    (if_fetch_cnt),
    .redirect_cnt (if_redirect_cnt),
    .stall_cnt    (if_stall_cnt)
  );
`else
  assign if_fetch_cnt    = '0;
  assign if_redirect_cnt = '0;
  assign if_stall_cnt    = '0;
`endif

endmodule
